// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: FSM states, grant codes, grant picker.
// Pure declarations, no timing.
// No flow control of its own.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

package mem_pkg;

  localparam int WORD_W = `WORD_SIZE;
  localparam int LINE_W = `CACHE_LINE_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_I = 2'd0,
    GNT_D = 2'd1,
    GNT_W = 2'd2
  } gnt_t;

  // Writebacks always win; read ties go to whichever side was not served last.
  function automatic gnt_t pick_grant(input logic w_vld, input logic d_vld,
                                      input logic i_vld, input logic last_d);
    if (w_vld) return GNT_W;
    if (d_vld && i_vld) return last_d ? GNT_I : GNT_D;
    if (d_vld) return GNT_D;
    return GNT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (I/D cache) and memory-side handshake bundle for the arbiter.
// Wires only, no latency.
// Downstream backpressure carried by m_ready; core side is pulse based.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_W,
  parameter int LINE_SIZE = LINE_W
);
  logic                 i_read;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_res;
  logic [LINE_SIZE-1:0] i_res_data;
  logic [WORD_SIZE-1:0] i_res_addr;

  logic                 d_read;
  logic [WORD_SIZE-1:0] d_addr;
  logic                 d_res;
  logic [LINE_SIZE-1:0] d_res_data;
  logic [WORD_SIZE-1:0] d_res_addr;

  logic                 d_wenable;
  logic [LINE_SIZE-1:0] d_w_data;
  logic [WORD_SIZE-1:0] d_w_addr;

  logic                 m_req;
  logic                 m_we;
  logic [WORD_SIZE-1:0] m_addr;
  logic [LINE_SIZE-1:0] m_wdata;
  logic                 m_ready;
  logic                 m_res;
  logic [LINE_SIZE-1:0] m_res_data;

  // Arbiter side.
  modport slave (
    input  i_read, i_addr, d_read, d_addr, d_wenable, d_w_data, d_w_addr,
    output i_res, i_res_data, i_res_addr, d_res, d_res_data, d_res_addr,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_res, m_res_data
  );

  // Caches plus memory side.
  modport master (
    output i_read, i_addr, d_read, d_addr, d_wenable, d_w_data, d_w_addr,
    input  i_res, i_res_data, i_res_addr, d_res, d_res_data, d_res_addr,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_res, m_res_data
  );
endinterface

// File: rtl/defines.sv
// Global width macros shared by the memory arbiter slice.
// WORD_SIZE is the address width, CACHE_LINE_SIZE the line data width.
// Each macro is guarded so the file can be included or compiled more than once.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

// File: rtl/mem_req_slot.sv
// One-entry request holder: valid flag, address and optional line data.
// Set visible one cycle after the pulse.
// A set while occupied is dropped unless the entry is being cleared that same cycle.
module mem_req_slot #(
  parameter int AW       = 32,
  parameter int DW       = 128,
  parameter bit HAS_DATA = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          clr,
  input  logic [AW-1:0] set_addr,
  input  logic [DW-1:0] set_data,
  output logic          vld,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic take;

  // First request wins; a clear in the same cycle makes room for the new one.
  assign take = set && (!vld || clr);

  // Occupancy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      vld <= 1'b0;
    else if (take) vld <= 1'b1;
    else if (clr)  vld <= 1'b0;
  end

  // Address captured only when the request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      addr <= '0;
    else if (take) addr <= set_addr;
  end

  if (HAS_DATA) begin : g_data
    // Line payload captured alongside the address.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      data <= '0;
      else if (take) data <= set_data;
    end
  end else begin : g_nodata
    logic unused_set_data;
    assign unused_set_data = ^set_data;
    assign data = '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-read, D-read and D-writeback slots onto one downstream port.
// Read: pulse to m_req 2 cycles, response 1 cycle after m_res; one transaction in flight.
// m_req/m_addr/m_wdata held until m_ready; new requests queue in their slot meanwhile.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int LINE_SIZE = `CACHE_LINE_SIZE
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t state;
  gnt_t   gnt;
  gnt_t   gnt_next;
  logic   last_d;

  logic                 i_vld, d_vld, w_vld;
  logic [WORD_SIZE-1:0] i_slot_addr, d_slot_addr, w_slot_addr;
  logic [LINE_SIZE-1:0] i_slot_data, d_slot_data, w_slot_data;
  logic                 i_clr, d_clr, w_clr, rd_done;
  logic [WORD_SIZE-1:0] sel_addr;
  logic [LINE_SIZE-1:0] sel_data;

  // Writes retire on acceptance; reads retire when their data comes back.
  assign w_clr   = (state == ST_ISSUE) && (gnt == GNT_W) && bus.m_ready;
  assign rd_done = (state == ST_WAIT) && bus.m_res;
  assign i_clr   = rd_done && (gnt == GNT_I);
  assign d_clr   = rd_done && (gnt == GNT_D);

  assign gnt_next = pick_grant(w_vld, d_vld, i_vld, last_d);

  mem_req_slot #(.AW(WORD_SIZE), .DW(LINE_SIZE), .HAS_DATA(1'b0)) u_i_slot (
    .clk(clk), .rst(rst), .set(bus.i_read), .clr(i_clr),
    .set_addr(bus.i_addr), .set_data('0),
    .vld(i_vld), .addr(i_slot_addr), .data(i_slot_data)
  );

  mem_req_slot #(.AW(WORD_SIZE), .DW(LINE_SIZE), .HAS_DATA(1'b0)) u_d_slot (
    .clk(clk), .rst(rst), .set(bus.d_read), .clr(d_clr),
    .set_addr(bus.d_addr), .set_data('0),
    .vld(d_vld), .addr(d_slot_addr), .data(d_slot_data)
  );

  mem_req_slot #(.AW(WORD_SIZE), .DW(LINE_SIZE), .HAS_DATA(1'b1)) u_w_slot (
    .clk(clk), .rst(rst), .set(bus.d_wenable), .clr(w_clr),
    .set_addr(bus.d_w_addr), .set_data(bus.d_w_data),
    .vld(w_vld), .addr(w_slot_addr), .data(w_slot_data)
  );

  // Address/data of the slot that would be granted this cycle.
  always_comb begin
    sel_addr = i_slot_addr;
    sel_data = i_slot_data;
    case (gnt_next)
      GNT_W: begin
        sel_addr = w_slot_addr;
        sel_data = w_slot_data;
      end
      GNT_D: begin
        sel_addr = d_slot_addr;
        sel_data = d_slot_data;
      end
      default: ;
    endcase
  end

  // Control FSM with registered downstream request and core response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      gnt            <= GNT_I;
      last_d         <= 1'b0;
      bus.m_req      <= 1'b0;
      bus.m_we       <= 1'b0;
      bus.m_addr     <= '0;
      bus.m_wdata    <= '0;
      bus.i_res      <= 1'b0;
      bus.i_res_data <= '0;
      bus.i_res_addr <= '0;
      bus.d_res      <= 1'b0;
      bus.d_res_data <= '0;
      bus.d_res_addr <= '0;
    end else begin
      bus.i_res <= 1'b0;
      bus.d_res <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_vld || d_vld || w_vld) begin
            gnt         <= gnt_next;
            bus.m_req   <= 1'b1;
            bus.m_we    <= (gnt_next == GNT_W);
            bus.m_addr  <= sel_addr;
            bus.m_wdata <= sel_data;
            if (gnt_next != GNT_W) last_d <= (gnt_next == GNT_D);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.m_ready) begin
            bus.m_req <= 1'b0;
            state     <= (gnt == GNT_W) ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.m_res) begin
            if (gnt == GNT_D) begin
              bus.d_res      <= 1'b1;
              bus.d_res_data <= bus.m_res_data;
              bus.d_res_addr <= d_slot_addr;
            end else begin
              bus.i_res      <= 1'b1;
              bus.i_res_data <= bus.m_res_data;
              bus.i_res_addr <= i_slot_addr;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (32), address width.
REQ-002 Parameter LINE_SIZE, default `CACHE_LINE_SIZE (128), line data width.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line read request pulse; i_addr in WORD_SIZE.
- i_res  out  1  I read response pulse; i_res_data out LINE_SIZE; i_res_addr out WORD_SIZE.
- d_read  in  1  D-cache line read request pulse; d_addr in WORD_SIZE.
- d_res  out  1  D read response pulse; d_res_data out LINE_SIZE; d_res_addr out WORD_SIZE.
- d_wenable  in  1  D-cache line writeback pulse; d_w_data in LINE_SIZE; d_w_addr in WORD_SIZE.
- m_req  out  1  downstream request valid; m_we out 1 (1 = write); m_addr out WORD_SIZE; m_wdata out LINE_SIZE.
- m_ready  in  1  downstream accepts request when m_req && m_ready.
- m_res  in  1  downstream read data valid; m_res_data in LINE_SIZE.

Function
REQ-004 Three one-entry slots (I-read, D-read, D-write), each holding valid flag plus address (plus data for write); a request pulse sets its slot at the sampling edge.
REQ-005 A request pulse whose slot is already valid and not being freed that cycle is ignored (first request wins).
REQ-006 Slot freed and new pulse of same type in the same cycle: slot ends valid with the new request.
REQ-007 FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-008 IDLE: if any slot valid, latch grant and go to ISSUE next cycle; else stay.
REQ-009 Grant priority: D-write first; between D-read and I-read, alternate using a last-read-grant bit (reset value: I granted last, so D wins first tie).
REQ-010 ISSUE: m_req=1 with m_we/m_addr/m_wdata from granted slot, held stable until m_ready; on accept, write slot freed and go to IDLE, read goes to WAIT.
REQ-011 WAIT: on m_res, capture m_res_data; next cycle assert exactly one of i_res/d_res for one cycle with data and the granted slot's address; free slot; go IDLE.
REQ-012 Minimum read latency: pulse at cycle 0 -> m_req at cycle 2 -> with m_ready=1 and m_res at cycle 3, response pulse at cycle 4.
REQ-013 Writes generate no core-side response; m_res in IDLE or ISSUE is ignored.
REQ-014 At most one downstream transaction outstanding; m_req is 0 outside ISSUE.
REQ-015 i_res_data/d_res_data and addr outputs hold last value between pulses.

Reset
REQ-016 rst low asynchronously clears all slot valid flags, FSM to IDLE, last-read-grant to I, m_req/m_we/i_res/d_res to 0, data/address outputs to 0.
REQ-017 Reset mid-transaction abandons it; a late m_res after reset release is ignored per REQ-013.
REQ-018 Requests sampled while rst low are discarded.

Structure
REQ-019 Package mem_pkg holds FSM state enum and grant enum (GNT_I, GNT_D, GNT_W); widths come from defines.sv.
REQ-020 Sub-module mem_req_slot (valid, addr, optional data, set/clear) instantiated three times; arbitration and FSM in mem_arbiter.

Verification
REQ-021 i_read at 0x100, m_ready=1, m_res one cycle after accept with data 0xA5.. -> i_res one cycle later, i_res_addr=0x100, d_res=0.
REQ-022 i_read, d_read, d_wenable same cycle -> downstream order write, D read, I read; d_res before i_res.
REQ-023 Back-to-back contention, repeated I and D reads -> grants alternate D, I, D, I.
REQ-024 m_ready low 5 cycles during ISSUE -> m_req, m_addr, m_wdata stable all 5 cycles; one transaction only.
REQ-025 Second i_read while I slot valid -> ignored; exactly one i_res, address of the first.
REQ-026 rst low during WAIT, m_res after release -> no i_res/d_res, FSM IDLE, all slots empty.
